alu_share_arbiter: RTL and testbench

- Shares the single-cycle combinational ALU between two requesters, e.g. port 0 = execute stage and port 1 = address/branch-target unit.
- Round-robin arbitration with a valid/ready request handshake.
- Registers the operands and control onto the shared ALU, then captures the result and zero flag.
- Returns the result to the winning requester on a per-port response handshake with backpressure.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/alu_share_arbiter_if.sv | 27 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 12 +
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU share arbiter:
// ALU control codes, FSM state encoding and the legal-op check.
package alu_arb_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADD4 = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_ADD4,
            ALU_SUB, ALU_SLT, ALU_NOR: op_legal = 1'b1;
            default:                  op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's view of the shared ALU: request handshake in,
// response handshake out. The arbiter takes the slave modport.
interface alu_share_arbiter_if #(
    parameter int DW = 32,
    parameter int CW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_ctrl;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;
    logic          rsp_err;

    modport master (
        output req_valid, req_ctrl, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, on contention
// the port that did not win last time is chosen.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any_valid
);
    assign any_valid = valid0 | valid1;
    assign grant     = (valid0 && valid1) ? ~last_grant : valid1;
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_OPCHECK_EN to reject illegal control codes with rsp_err.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   port0,
    alu_share_arbiter_if.slave   port1,
    output logic [DW-1:0]        alu_data1,
    output logic [DW-1:0]        alu_data2,
    output logic [CW-1:0]        alu_control,
    input  logic [DW-1:0]        alu_result,
    input  logic                 alu_zero
);

    state_t        state;
    logic          last_grant;
    logic          cur;
    logic          grant;
    logic          any_valid;
    logic          idle;
    logic          accept;
    logic          rsp_ready_sel;
    logic [CW-1:0] sel_ctrl;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;

    logic [1:0]    rsp_valid_q;
    logic [1:0]    rsp_zero_q;
    logic [DW-1:0] rsp_result_q [2];
`ifdef ALU_ARB_OPCHECK_EN
    logic [1:0]    rsp_err_q;
`endif

    rr_arb2 u_rr_arb2 (
        .valid0     (port0.req_valid),
        .valid1     (port1.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    assign idle = (state == IDLE);

    // Ready only goes to a port that is actually requesting and granted.
    assign port0.req_ready = !reset && idle && port0.req_valid && !grant;
    assign port1.req_ready = !reset && idle && port1.req_valid &&  grant;
    assign accept          = !reset && idle && any_valid;

    assign sel_ctrl      = grant ? port1.req_ctrl : port0.req_ctrl;
    assign sel_a         = grant ? port1.req_a    : port0.req_a;
    assign sel_b         = grant ? port1.req_b    : port0.req_b;
    assign rsp_ready_sel = cur   ? port1.rsp_ready : port0.rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            cur             <= 1'b0;
            alu_data1       <= '0;
            alu_data2       <= '0;
            alu_control     <= '0;
            rsp_valid_q     <= '0;
            rsp_zero_q      <= '0;
            rsp_result_q[0] <= '0;
            rsp_result_q[1] <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            rsp_err_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant;
                        cur        <= grant;
`ifdef ALU_ARB_OPCHECK_EN
                        // Illegal codes never reach the ALU; answer directly.
                        if (!op_legal(sel_ctrl)) begin
                            rsp_valid_q[grant]  <= 1'b1;
                            rsp_result_q[grant] <= '0;
                            rsp_zero_q[grant]   <= 1'b0;
                            rsp_err_q[grant]    <= 1'b1;
                            state               <= RESP;
                        end else begin
                            alu_control <= sel_ctrl;
                            alu_data1   <= sel_a;
                            alu_data2   <= sel_b;
                            state       <= EXEC;
                        end
`else
                        alu_control <= sel_ctrl;
                        alu_data1   <= sel_a;
                        alu_data2   <= sel_b;
                        state       <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    rsp_valid_q[cur]  <= 1'b1;
                    rsp_result_q[cur] <= alu_result;
                    rsp_zero_q[cur]   <= alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
                    rsp_err_q[cur]    <= 1'b0;
`endif
                    state             <= RESP;
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        rsp_valid_q[cur] <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign port0.rsp_valid  = rsp_valid_q[0];
    assign port0.rsp_result = rsp_result_q[0];
    assign port0.rsp_zero   = rsp_zero_q[0];
    assign port1.rsp_valid  = rsp_valid_q[1];
    assign port1.rsp_result = rsp_result_q[1];
    assign port1.rsp_zero   = rsp_zero_q[1];
`ifdef ALU_ARB_OPCHECK_EN
    assign port0.rsp_err    = rsp_err_q[0];
    assign port1.rsp_err    = rsp_err_q[1];
`else
    assign port0.rsp_err    = 1'b0;
    assign port1.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push expected
// responses, a negedge monitor pops and compares on every response handshake.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DW(32), .CW(4)) p0 ();
    alu_share_arbiter_if #(.DW(32), .CW(4)) p1 ();

    logic [31:0] alu_data1, alu_data2, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;

    alu_share_arbiter #(.DW(32), .CW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .port0       (p0),
        .port1       (p1),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Reference ALU attached to the arbiter; unknown codes give a marker value.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_control)
            4'b0000: alu_result = alu_data1 & alu_data2;
            4'b0001: alu_result = alu_data1 | alu_data2;
            4'b0010: alu_result = alu_data1 + alu_data2;
            4'b0011: alu_result = alu_data1 + 32'd4;
            4'b0110: alu_result = alu_data1 - alu_data2;
            4'b0111: alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_data1 | alu_data2);
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   glog[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] r, input logic z, input logic e);
        exp_t t;
        t.result = r;
        t.zero   = z;
        t.err    = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (p0.rsp_valid && p0.rsp_ready) begin
                if (q0.size() == 0) fail_now("rsp0_unexpected");
                else begin
                    e0 = q0.pop_front();
                    chk("rsp0_result", p0.rsp_result, e0.result);
                    chk("rsp0_zero", p0.rsp_zero, e0.zero);
                    chk("rsp0_err", p0.rsp_err, e0.err);
                end
            end
            if (p1.rsp_valid && p1.rsp_ready) begin
                if (q1.size() == 0) fail_now("rsp1_unexpected");
                else begin
                    e1 = q1.pop_front();
                    chk("rsp1_result", p1.rsp_result, e1.result);
                    chk("rsp1_zero", p1.rsp_zero, e1.zero);
                    chk("rsp1_err", p1.rsp_err, e1.err);
                end
            end
            if (p0.rsp_valid || p1.rsp_valid)
                chk("rsp_onehot", p0.rsp_valid & p1.rsp_valid, 0);
        end
    end

    task automatic start_req(input int port, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            p0.req_ctrl = c; p0.req_a = a; p0.req_b = b; p0.req_valid = 1'b1;
        end else begin
            p1.req_ctrl = c; p1.req_a = a; p1.req_b = b; p1.req_valid = 1'b1;
        end
    endtask

    // Waits for the accept handshake, optionally records the expected response,
    // and drops valid just after the accepting edge.
    task automatic wait_acc(input int port, input logic [31:0] er, input logic ez, input logic ee,
                            input bit push, output int acc_cyc);
        bit done = 0;
        acc_cyc = -1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (port == 0 ? (p0.req_valid && p0.req_ready) : (p1.req_valid && p1.req_ready)) begin
                done = 1;
                acc_cyc = cyc;
                if (push) begin
                    if (port == 0) q0.push_back(mk(er, ez, ee));
                    else           q1.push_back(mk(er, ez, ee));
                end
            end
        end
        if (!done) fail_now("accept_timeout");
        @(posedge clk); #1;
        if (port == 0) p0.req_valid = 1'b0;
        else           p1.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && !p0.rsp_valid && !p1.rsp_valid) break;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    int c_a, c_b, n0, n1;

    initial begin
        p0.req_valid = 0; p0.req_ctrl = 0; p0.req_a = 0; p0.req_b = 0; p0.rsp_ready = 1;
        p1.req_valid = 0; p1.req_ctrl = 0; p1.req_a = 0; p1.req_b = 0; p1.rsp_ready = 1;

        // Reset state, with a request already pending.
        start_req(0, ALU_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("rst_req0_ready", p0.req_ready, 0);
        chk("rst_rsp0_valid", p0.rsp_valid, 0);
        chk("rst_rsp1_valid", p1.rsp_valid, 0);
        chk("rst_rsp0_result", p0.rsp_result, 0);
        chk("rst_alu_control", alu_control, 0);
        chk("rst_alu_data1", alu_data1, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single op: ADD 5+7 on port 0, 2-cycle latency.
        wait_acc(0, 32'd12, 1'b0, 1'b0, 1, c_a);
        @(negedge clk);
        chk("t1_alu_control", alu_control, ALU_ADD);
        chk("t1_alu_data1", alu_data1, 32'd5);
        chk("t1_rsp0_early", p0.rsp_valid, 0);
        @(negedge clk);
        chk("t1_rsp0_valid", p0.rsp_valid, 1);
        chk("t1_rsp1_valid", p1.rsp_valid, 0);
        drain();

        // Contention fairness from reset: grants 0,1,0,1.
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        start_req(0, ALU_SUB, 32'd9, 32'd9);
        start_req(1, ALU_OR, 32'hF0, 32'h0F);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
            @(negedge clk);
            if (p0.req_valid && p0.req_ready) begin
                glog.push_back(0); q0.push_back(mk(32'd0, 1'b1, 1'b0)); n0++;
            end
            if (p1.req_valid && p1.req_ready) begin
                glog.push_back(1); q1.push_back(mk(32'hFF, 1'b0, 1'b0)); n1++;
            end
            @(posedge clk); #1;
            if (n0 >= 2) p0.req_valid = 1'b0;
            if (n1 >= 2) p1.req_valid = 1'b0;
        end
        chk("fair_count", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_grant%0d", i), (i < glog.size()) ? glog[i] : 9, i % 2);
        drain();

        // Backpressure on port 1 with port 0 waiting.
        p1.rsp_ready = 1'b0;
        start_req(1, ALU_ADD, 32'h10, 32'h20);
        wait_acc(1, 32'h30, 1'b0, 1'b0, 1, c_a);
        start_req(0, ALU_AND, 32'hFF, 32'h0F);
        for (int i = 0; i < 10 && !p1.rsp_valid; i++) @(negedge clk);
        if (!p1.rsp_valid) fail_now("bp_rsp1_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", p1.rsp_valid, 1);
            chk("bp_result", p1.rsp_result, 32'h30);
            chk("bp_zero", p1.rsp_zero, 0);
            chk("bp_req0_ready", p0.req_ready, 0);
            chk("bp_req1_ready", p1.req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        p1.rsp_ready = 1'b1;
        wait_acc(0, 32'h0F, 1'b0, 1'b0, 1, c_b);
        chk("bp_rsp1_cleared", p1.rsp_valid, 0);
        drain();

        // Reset while in EXEC aborts the op; port 0 wins first afterwards.
        start_req(1, ALU_ADD, 32'd1, 32'd1);
        wait_acc(1, 32'd2, 1'b0, 1'b0, 0, c_a);
        reset = 1'b1;
        start_req(0, ALU_ADD, 32'd2, 32'd2);
        start_req(1, ALU_ADD, 32'd3, 32'd3);
        @(negedge clk);
        chk("rx_rsp0_valid", p0.rsp_valid, 0);
        chk("rx_rsp1_valid", p1.rsp_valid, 0);
        chk("rx_rsp1_result", p1.rsp_result, 0);
        chk("rx_alu_control", alu_control, 0);
        chk("rx_alu_data1", alu_data1, 0);
        chk("rx_alu_data2", alu_data2, 0);
        chk("rx_req0_ready", p0.req_ready, 0);
        chk("rx_req1_ready", p1.req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        fork
            wait_acc(0, 32'd4, 1'b0, 1'b0, 1, c_a);
            begin
                @(negedge clk);
                chk("rx_first_req1_ready", p1.req_ready, 0);
            end
        join
        wait_acc(1, 32'd6, 1'b0, 1'b0, 1, c_b);
        drain();

        // Illegal control code 1111 on port 1.
`ifdef ALU_ARB_OPCHECK_EN
        start_req(1, 4'b1111, 32'd7, 32'd7);
        wait_acc(1, 32'd0, 1'b0, 1'b1, 1, c_a);
        @(negedge clk);
        chk("ill_rsp1_valid", p1.rsp_valid, 1);
        chk("ill_alu_control", alu_control, ALU_ADD);
`else
        start_req(1, 4'b1111, 32'd7, 32'd7);
        wait_acc(1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, c_a);
        @(negedge clk);
        chk("ill_alu_control", alu_control, 4'b1111);
        chk("ill_rsp1_early", p1.rsp_valid, 0);
        @(negedge clk);
        chk("ill_rsp1_valid", p1.rsp_valid, 1);
        chk("ill_rsp1_err", p1.rsp_err, 0);
`endif
        drain();

        // SLT then A+4 back to back: accepts exactly 3 cycles apart.
        start_req(0, ALU_SLT, 32'd3, 32'd8);
        wait_acc(0, 32'd1, 1'b0, 1'b0, 1, c_a);
        start_req(0, ALU_ADD4, 32'h100, 32'd0);
        wait_acc(0, 32'h104, 1'b0, 1'b0, 1, c_b);
        chk("b2b_spacing", c_b - c_a, 3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
